// File: rtl/scroll_pkg.sv
// Shared types and defaults for the digit-window scroll controller.
// Debouncer state codes are fixed at 2 bits.
package scroll_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'b00,
        PRESS_WAIT   = 2'b01,
        HELD         = 2'b10,
        RELEASE_WAIT = 2'b11
    } db_state_t;

    localparam int DEF_TICK_DIV       = 30000;
    localparam int DEF_DEBOUNCE_TICKS = 4;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus tick-sampled debouncer for one push-button.
// press pulses for one clk cycle each time the button qualifies as held.
module btn_debounce
    import scroll_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic raw,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_TICKS - 1);

    logic [1:0]       sync;
    db_state_t        state;
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= '0;
            state <= RELEASED;
            count <= '0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], raw};
            press <= 1'b0;
            if (tick) begin
                unique case (state)
                    RELEASED: begin
                        if (sync[1]) begin
                            if (DEBOUNCE_TICKS == 1) begin
                                state <= HELD;
                                count <= '0;
                                press <= 1'b1;
                            end else begin
                                state <= PRESS_WAIT;
                                count <= CNT_W'(1);
                            end
                        end
                    end
                    PRESS_WAIT: begin
                        if (!sync[1]) begin
                            state <= RELEASED;
                            count <= '0;
                        end else if (count == LAST) begin
                            state <= HELD;
                            count <= '0;
                            press <= 1'b1;
                        end else begin
                            count <= count + CNT_W'(1);
                        end
                    end
                    HELD: begin
                        if (!sync[1]) begin
                            if (DEBOUNCE_TICKS == 1) begin
                                state <= RELEASED;
                                count <= '0;
                            end else begin
                                state <= RELEASE_WAIT;
                                count <= CNT_W'(1);
                            end
                        end
                    end
                    RELEASE_WAIT: begin
                        if (sync[1]) begin
                            state <= HELD;
                            count <= '0;
                        end else if (count == LAST) begin
                            state <= RELEASED;
                            count <= '0;
                        end else begin
                            count <= count + CNT_W'(1);
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/scroll_ctrl.sv
// Digit-window scroll controller: debounced left/right buttons move pos.
// Define SCROLL_WRAP_EN to wrap around at the ends instead of clamping.
module scroll_ctrl
    import scroll_pkg::*;
#(
    parameter int NUM_POS        = 3,
    parameter int TICK_DIV       = DEF_TICK_DIV,
    parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
    localparam int POS_W         = $clog2(NUM_POS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             right_but,
    input  logic             left_but,
    output logic [POS_W-1:0] pos,
    output logic             at_home,
    output logic             at_end,
    output logic             step
);

    localparam int TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [POS_W-1:0] POS_LAST  = POS_W'(NUM_POS - 1);

    logic [TW-1:0] tcnt;
    logic          tick;
    logic          right_press;
    logic          left_press;

    assign tick = (tcnt == TICK_LAST);

    always_ff @(posedge clk) begin
        if (rst || tick) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + TW'(1);
        end
    end

    btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_right (
        .clk   (clk),
        .rst   (rst),
        .tick  (tick),
        .raw   (right_but),
        .press (right_press)
    );

    btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_left (
        .clk   (clk),
        .rst   (rst),
        .tick  (tick),
        .raw   (left_but),
        .press (left_press)
    );

    // clear wins over any press arriving on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            pos  <= '0;
            step <= 1'b0;
        end else begin
            step <= 1'b0;
            if (clear) begin
                pos <= '0;
            end else if (right_press && !left_press) begin
                if (pos != POS_LAST) begin
                    pos  <= pos + POS_W'(1);
                    step <= 1'b1;
                end
`ifdef SCROLL_WRAP_EN
                else begin
                    pos  <= '0;
                    step <= 1'b1;
                end
`endif
            end else if (left_press && !right_press) begin
                if (pos != '0) begin
                    pos  <= pos - POS_W'(1);
                    step <= 1'b1;
                end
`ifdef SCROLL_WRAP_EN
                else begin
                    pos  <= POS_LAST;
                    step <= 1'b1;
                end
`endif
            end
        end
    end

    assign at_home = (pos == '0);
    assign at_end  = (pos == POS_LAST);

endmodule

// File: tb/tb_scroll_ctrl.sv
// Self-checking bench for scroll_ctrl: directed scenarios then random
// button activity, each cycle checked against a behavioural model.
module tb_scroll_ctrl;

    localparam int NP = 5;
    localparam int TD = 4;
    localparam int DT = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic       right_but = 1'b0;
    logic       left_but = 1'b0;
    logic [2:0] pos;
    logic       at_home;
    logic       at_end;
    logic       step;

    int npass = 0;
    int ntot  = 0;

    scroll_ctrl #(
        .NUM_POS        (NP),
        .TICK_DIV       (TD),
        .DEBOUNCE_TICKS (DT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .right_but (right_but),
        .left_but  (left_but),
        .pos       (pos),
        .at_home   (at_home),
        .at_end    (at_end),
        .step      (step)
    );

    always #5 clk = ~clk;

    // Model: button level flips after DT agreeing tick samples of the
    // two-cycle-delayed input; index 0 = right, 1 = left.
    int m_tcnt = 0;
    bit m_d1 [2] = '{0, 0};
    bit m_d2 [2] = '{0, 0};
    bit m_lvl [2] = '{0, 0};
    int m_run [2] = '{0, 0};
    bit m_prs [2] = '{0, 0};
    int m_pos = 0;
    bit m_step = 0;

    task automatic model_step(input bit r, input bit l, input bit c,
                              input bit rs);
        bit tick;
        bit np [2];
        bit raw [2];
        raw[0] = r;
        raw[1] = l;
        if (rs) begin
            m_tcnt = 0;
            m_pos  = 0;
            m_step = 0;
            for (int b = 0; b < 2; b++) begin
                m_d1[b] = 0; m_d2[b] = 0; m_lvl[b] = 0;
                m_run[b] = 0; m_prs[b] = 0;
            end
            return;
        end
        tick = (m_tcnt == TD - 1);
        for (int b = 0; b < 2; b++) begin
            np[b] = 0;
            if (tick) begin
                if (m_d2[b] != m_lvl[b]) begin
                    m_run[b]++;
                    if (m_run[b] == DT) begin
                        m_lvl[b] = m_d2[b];
                        m_run[b] = 0;
                        np[b] = m_d2[b];
                    end
                end else begin
                    m_run[b] = 0;
                end
            end
        end
        m_step = 0;
        if (c) begin
            m_pos = 0;
        end else if (m_prs[0] && !m_prs[1]) begin
            if (m_pos < NP - 1) begin
                m_pos++; m_step = 1;
            end else begin
`ifdef SCROLL_WRAP_EN
                m_pos = 0; m_step = 1;
`endif
            end
        end else if (m_prs[1] && !m_prs[0]) begin
            if (m_pos > 0) begin
                m_pos--; m_step = 1;
            end else begin
`ifdef SCROLL_WRAP_EN
                m_pos = NP - 1; m_step = 1;
`endif
            end
        end
        for (int b = 0; b < 2; b++) begin
            m_prs[b] = np[b];
            m_d2[b]  = m_d1[b];
            m_d1[b]  = raw[b];
        end
        m_tcnt = (m_tcnt + 1) % TD;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic cyc(input bit r, input bit l, input bit c, input bit rs);
        right_but = r;
        left_but  = l;
        clear     = c;
        rst       = rs;
        @(posedge clk);
        model_step(r, l, c, rs);
        #1;
        chk("pos", 32'(pos), 32'(m_pos));
        chk("step", 32'(step), 32'(m_step));
        chk("at_home", 32'(at_home), 32'(m_pos == 0));
        chk("at_end", 32'(at_end), 32'(m_pos == NP - 1));
    endtask

    task automatic press(input bit r, input bit l, input int hold,
                         input int rel);
        for (int i = 0; i < hold; i++) cyc(r, l, 0, 0);
        for (int i = 0; i < rel; i++) cyc(0, 0, 0, 0);
    endtask

    initial begin
        int exp_pos;
        bit hit;
        bit r, l, clr, rs, bnc;
        int len;

        // reset
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
        chk("rst_pos", 32'(pos), 32'd0);
        chk("rst_home", 32'(at_home), 32'd1);
        chk("rst_end", 32'(at_end), 32'd0);
        chk("rst_step", 32'(step), 32'd0);

        // clean presses up to the far end
        press(1, 0, 40, 20);
        chk("first_press", 32'(pos), 32'd1);
        for (int i = 0; i < 3; i++) press(1, 0, 40, 20);
        chk("four_press", 32'(pos), 32'd4);
        chk("four_end", 32'(at_end), 32'd1);

        // bounce never qualifies
        for (int i = 0; i < 30; i++) cyc((i / 3) % 2 == 0, 0, 0, 0);
        press(0, 0, 0, 20);
        chk("bounce_pos", 32'(pos), 32'd4);

        // right press at the far end
        press(1, 0, 40, 20);
`ifdef SCROLL_WRAP_EN
        exp_pos = 0;
`else
        exp_pos = 4;
`endif
        chk("right_at_end", 32'(pos), 32'(exp_pos));

        // both buttons together at pos 2
        cyc(0, 0, 1, 0);
        press(1, 0, 40, 20);
        press(1, 0, 40, 20);
        chk("pos_two", 32'(pos), 32'd2);
        press(1, 1, 40, 20);
        chk("both_pos", 32'(pos), 32'd2);

        // left press at home
        cyc(0, 0, 1, 0);
        press(0, 1, 40, 20);
`ifdef SCROLL_WRAP_EN
        exp_pos = 4;
`else
        exp_pos = 0;
`endif
        chk("left_at_home", 32'(pos), 32'(exp_pos));

        // clear coincident with a press pulse at pos 3
        cyc(0, 0, 1, 0);
        for (int i = 0; i < 3; i++) press(1, 0, 40, 20);
        chk("pos_three", 32'(pos), 32'd3);
        hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            hit = m_prs[0];
            cyc(1, 0, m_prs[0], 0);
        end
        press(1, 0, 40, 20);
        chk("clear_pos", 32'(pos), 32'd0);

        // reset mid PRESS_WAIT, button kept held
        press(1, 0, 10, 0);
        cyc(1, 0, 0, 1);
        press(1, 0, 40, 20);
        chk("rst_requal", 32'(pos), 32'd1);

        // random activity
        for (int s = 0; s < 250; s++) begin
            r   = 1'($urandom_range(0, 1));
            l   = ($urandom_range(0, 3) == 0);
            clr = ($urandom_range(0, 15) == 0);
            rs  = ($urandom_range(0, 63) == 0);
            bnc = ($urandom_range(0, 3) == 0);
            len = $urandom_range(1, 30);
            for (int i = 0; i < len; i++) begin
                if (bnc) r = 1'($urandom_range(0, 1));
                cyc(r, l, clr && i == 0, rs && i == 0);
            end
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
